// File: rtl/punto5_pkg.sv
// Shared types and constants for the punto5 sweep controller.
// Holds the FSM state type, sweep size and the mismatch helper.
package punto5_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_COMB   = 8;
    localparam int F_CASE_BIT = 0;

    // The four implementations agree only when all bits are equal.
    function automatic logic f_mismatch(input logic [3:0] f);
        return !(f == 4'b0000 || f == 4'b1111);
    endfunction

endpackage

// File: rtl/punto5_settle_timer.sv
// Loadable 4-bit down-counter with zero flag; times the settle interval.
// Ports: clk_i, rst_i (sync, active-high), load_i/load_val_i, dec_i, cnt_o, zero_o.
module punto5_settle_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic [3:0] cnt_o,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load wins over decrement; the counter saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/punto5_sweep_ctrl.sv
// Sweeps A,B,C through 0..7, samples four implementations and cross-checks them.
// Ports: clk_i, rst_i, start_i, f_in_i -> abc_out_o, busy_o, done_o, pass_o,
// tabla_o, err_mask_o, err_cnt_o, first_err_o. All outputs registered.
module punto5_sweep_ctrl
    import punto5_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] f_in_i,
    output logic [2:0] abc_out_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] tabla_o,
    output logic [7:0] err_mask_o,
    output logic [3:0] err_cnt_o,
    output logic [2:0] first_err_o
);

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] LAST   = 3'(NUM_COMB - 1);

    state_e     state_q;
    logic [2:0] abc_out_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] tabla_q;
    logic [7:0] err_mask_q;
    logic [3:0] err_cnt_q;
    logic [2:0] first_err_q;

    logic       tmr_load;
    logic       tmr_dec;
    logic       tmr_zero;
    logic [3:0] tmr_cnt;
    logic       mm;

    assign mm = f_mismatch(f_in_i);

    // Reload on sweep launch and on every step to the next combination.
    assign tmr_load = (state_q == IDLE && start_i)
                   || (state_q == SAMPLE && abc_out_q != LAST);
    assign tmr_dec  = (state_q == SETTLE);

    punto5_settle_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (RELOAD),
        .dec_i      (tmr_dec),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            abc_out_q   <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            tabla_q     <= 8'd0;
            err_mask_q  <= 8'd0;
            err_cnt_q   <= 4'd0;
            first_err_q <= 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= SETTLE;
                        abc_out_q   <= 3'd0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        tabla_q     <= 8'd0;
                        err_mask_q  <= 8'd0;
                        err_cnt_q   <= 4'd0;
                        first_err_q <= 3'd0;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tabla_q[abc_out_q]    <= f_in_i[F_CASE_BIT];
                    err_mask_q[abc_out_q] <= mm;
                    if (mm) begin
                        err_cnt_q <= err_cnt_q + 4'd1;
                        // A zero count means no earlier mismatch this sweep.
                        if (err_cnt_q == 4'd0) begin
                            first_err_q <= abc_out_q;
                        end
                    end
                    if (abc_out_q == LAST) begin
                        state_q <= DONE;
                    end else begin
                        abc_out_q <= abc_out_q + 3'd1;
                        state_q   <= SETTLE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_mask_q == 8'd0);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign abc_out_o   = abc_out_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign tabla_o     = tabla_q;
    assign err_mask_o  = err_mask_q;
    assign err_cnt_o   = err_cnt_q;
    assign first_err_o = first_err_q;

endmodule

// File: tb/tb_punto5_sweep_ctrl.sv
// Bench for punto5_sweep_ctrl: randomized truth tables vs a sweep model.
// Two instances cover SETTLE_CYC=2 and SETTLE_CYC=1.
module tb_punto5_sweep_ctrl;

    localparam int S2 = 2;
    localparam int S1 = 1;
    localparam int L2 = 8 * (S2 + 1) + 1;
    localparam int L1 = 8 * (S1 + 1) + 1;

    typedef struct {
        logic [7:0] tabla;
        logic [7:0] mask;
        int         cnt;
        int         first;
        int         pass;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic start2, start1;
    logic [3:0] ftab2 [8];
    logic [3:0] ftab1 [8];

    logic [3:0] f2, f1;
    logic [2:0] abc2, abc1;
    logic       busy2, busy1, done2, done1, pass2, pass1;
    logic [7:0] tabla2, tabla1, mask2, mask1;
    logic [3:0] cnt2, cnt1;
    logic [2:0] first2, first1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign f2 = ftab2[abc2];
    assign f1 = ftab1[abc1];

    punto5_sweep_ctrl #(.SETTLE_CYC(S2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .f_in_i(f2),
        .abc_out_o(abc2), .busy_o(busy2), .done_o(done2),
        .pass_o(pass2), .tabla_o(tabla2), .err_mask_o(mask2),
        .err_cnt_o(cnt2), .first_err_o(first2)
    );

    punto5_sweep_ctrl #(.SETTLE_CYC(S1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .f_in_i(f1),
        .abc_out_o(abc1), .busy_o(busy1), .done_o(done1),
        .pass_o(pass1), .tabla_o(tabla1), .err_mask_o(mask1),
        .err_cnt_o(cnt1), .first_err_o(first1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic maj(input int i);
        logic [2:0] b;
        b = 3'(i);
        return (b[2] & b[1]) | (b[2] & b[0]) | (b[1] & b[0]);
    endfunction

    // Expected sweep result straight from a truth table of f_in words.
    function automatic res_t model(input logic [3:0] t [8]);
        res_t r;
        r.tabla = '0;
        r.mask  = '0;
        r.cnt   = 0;
        r.first = -1;
        for (int i = 0; i < 8; i++) begin
            r.tabla[i] = t[i][0];
            if (t[i] != 4'h0 && t[i] != 4'hF) begin
                r.mask[i] = 1'b1;
                r.cnt++;
                if (r.first < 0) r.first = i;
            end
        end
        if (r.first < 0) r.first = 0;
        r.pass = (r.cnt == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic chk_res2(input string tag, input res_t e);
        chk({tag, ".tabla"}, 32'(tabla2), 32'(e.tabla));
        chk({tag, ".mask"}, 32'(mask2), 32'(e.mask));
        chk({tag, ".cnt"}, 32'(cnt2), 32'(e.cnt));
        chk({tag, ".first"}, 32'(first2), 32'(e.first));
        chk({tag, ".pass"}, 32'(pass2), 32'(e.pass));
    endtask

    task automatic chk_zero2(input string tag);
        chk({tag, ".abc"}, 32'(abc2), 0);
        chk({tag, ".busy"}, 32'(busy2), 0);
        chk({tag, ".done"}, 32'(done2), 0);
        chk({tag, ".pass"}, 32'(pass2), 0);
        chk({tag, ".tabla"}, 32'(tabla2), 0);
        chk({tag, ".mask"}, 32'(mask2), 0);
        chk({tag, ".cnt"}, 32'(cnt2), 0);
        chk({tag, ".first"}, 32'(first2), 0);
    endtask

    task automatic fill_maj2();
        for (int i = 0; i < 8; i++) ftab2[i] = {4{maj(i)}};
    endtask

    // Launch a sweep on dut2 and follow it cycle by cycle to done.
    // pulse_k > 0 re-pulses start after edge pulse_k (must be ignored).
    task automatic sweep2(input string tag, input int pulse_k);
        res_t e;
        int   a;
        e = model(ftab2);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk({tag, ".abc0"}, 32'(abc2), 0);
        chk({tag, ".busy0"}, 32'(busy2), 1);
        chk({tag, ".done0"}, 32'(done2), 0);
        for (int k = 1; k <= L2; k++) begin
            start2 = (k == pulse_k + 1 && pulse_k > 0);
            tick();
            a = k / (S2 + 1);
            if (a > 7) a = 7;
            chk({tag, ".abc"}, 32'(abc2), 32'(a));
            chk({tag, ".busy"}, 32'(busy2), 32'(k < L2));
            chk({tag, ".done"}, 32'(done2), 32'(k >= L2));
        end
        start2 = 1'b0;
        chk_res2(tag, e);
    endtask

    initial begin
        res_t e;
        int   a;
        bit   hit;
        rst = 1'b1;
        start2 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ftab2[i] = 4'h0;
            ftab1[i] = {4{maj(i)}};
        end
        tick();
        tick();
        rst = 1'b0;
        chk_zero2("reset");

        fill_maj2();
        sweep2("maj", 0);

        fill_maj2();
        ftab2[5][2] = ~ftab2[5][2];
        ftab2[2][2] = ~ftab2[2][2];
        sweep2("fpos_err", 0);

        for (int i = 0; i < 8; i++) ftab2[i] = 4'b0000;
        sweep2("all0", 0);
        for (int i = 0; i < 8; i++) ftab2[i] = 4'b0111;
        sweep2("all7", 0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 1) == 1) ftab2[i] = {4{maj(i)}};
                else ftab2[i] = 4'($urandom_range(0, 15));
            end
            sweep2("rand", 0);
        end

        // Start pulsed while abc=4 and busy must not disturb the sweep.
        fill_maj2();
        sweep2("busy_start", 4 * (S2 + 1));
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("restart.done", 32'(done2), 0);
        chk("restart.busy", 32'(busy2), 1);
        chk("restart.pass", 32'(pass2), 0);
        for (int k = 1; k <= L2; k++) tick();
        chk("restart.done_end", 32'(done2), 1);

        // Reset mid-sweep discards everything.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if (abc2 == 3'd3) hit = 1'b1;
            else tick();
        end
        chk("wait_abc3", 32'(hit), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero2("midreset");
        tick();
        chk("midreset.idle", 32'(busy2), 0);
        sweep2("after_rst", 0);

        // SETTLE_CYC=1 with start held high: back-to-back sweeps.
        e = model(ftab1);
        start1 = 1'b1;
        tick();
        chk("s1.busy0", 32'(busy1), 1);
        for (int k = 1; k <= L1; k++) begin
            tick();
            a = k / (S1 + 1);
            if (a > 7) a = 7;
            chk("s1.abc", 32'(abc1), 32'(a));
            chk("s1.done", 32'(done1), 32'(k >= L1));
        end
        chk("s1.tabla", 32'(tabla1), 32'(e.tabla));
        chk("s1.mask", 32'(mask1), 32'(e.mask));
        chk("s1.pass", 32'(pass1), 32'(e.pass));
        tick();
        chk("s1.rebusy", 32'(busy1), 1);
        chk("s1.reabc", 32'(abc1), 0);
        chk("s1.redone", 32'(done1), 0);
        for (int k = 1; k <= L1; k++) tick();
        start1 = 1'b0;
        chk("s1.done2", 32'(done1), 1);
        chk("s1.tabla2", 32'(tabla1), 32'(e.tabla));
        chk("s1.cnt2", 32'(cnt1), 32'(e.cnt));
        tick();
        tick();
        chk("s1.idle", 32'(busy1), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/punto5_sweep_ctrl.md
Name: punto5_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the 3-input logic function block (inputs A, B, C; outputs Fsimp, Fpos, Fsop, Fcase) in hardware. It drives the eight input combinations in order, waits a settle interval for each, samples all four implementations, and cross-checks them. It captures the truth table and a per-combination mismatch map, then reports pass/fail. It sits between board-level start/status I/O and the function block.

Parameters:
SETTLE_CYC, 2, cycles abc_out is held before sampling; legal range 1..15 (0 illegal).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  level; sampled only in IDLE; launches a sweep.
f_in  in  4  {Fsimp, Fpos, Fsop, Fcase} from the function block; bit0 = Fcase.
abc_out  out  3  {A, B, C} drive to the function block; A = bit2.
busy  out  1  high while a sweep is in progress.
done  out  1  sticky; set at sweep end, cleared by the next accepted start.
pass  out  1  valid when done=1; high iff err_mask == 0.
tabla  out  8  captured Fcase truth table; bit i = Fcase at abc = i.
err_mask  out  8  bit i set if the four f_in bits disagree at abc = i.
err_cnt  out  4  number of set bits in err_mask, 0..8.
first_err  out  3  lowest abc with a mismatch; 0 if none.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE; abc_out=0, busy=0, done=0, pass=0, tabla=0, err_mask=0, err_cnt=0, first_err=0, settle counter=0. Reset overrides everything, including mid-sweep; the partial results are discarded.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0. When start=1 at an edge:
  - go to SETTLE with abc_out=0 and counter=SETTLE_CYC-1;
  - clear done, pass, tabla, err_mask, err_cnt, first_err;
  - set busy=1.
- SETTLE: abc_out held. If counter==0, go to SAMPLE; otherwise decrement. Occupies exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle), with i = abc_out:
  - tabla[i] <= f_in[0];
  - mismatch = !(f_in==4'b0000 || f_in==4'b1111); err_mask[i] <= mismatch;
  - if mismatch: err_cnt increments; if it is the first mismatch this sweep, first_err <= i.
  - If i==7, go to DONE. Otherwise abc_out <= i+1, counter reloads to SETTLE_CYC-1, go to SETTLE.
- abc_out never wraps during a sweep; 7 is terminal.
- DONE (1 cycle): busy=0, done=1, pass=(err_mask==0); then go to IDLE. done and pass stay set until the next accepted start or rst.
- Latency: each combination takes SETTLE_CYC+1 cycles. done is first visible after the 8*(SETTLE_CYC+1)+1-th rising edge following the edge that accepted start (25 for the default).
- start while busy=1 is ignored; it is not queued.
- start held high continuously: a new sweep starts on the first IDLE cycle after DONE, i.e. back-to-back sweeps.
- f_in is assumed stable during SETTLE and is never registered except in SAMPLE.
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package punto5_pkg:
  - state encoding localparams (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - NUM_COMB=8;
  - F_CASE_BIT=0.
- One natural sub-module, punto5_settle_timer: a loadable 4-bit down-counter with a zero flag, instantiated once.

Test Plan:
1. Model all four f_in bits as majority(A,B,C); start pulse, SETTLE_CYC=2 -> abc_out steps 0..7, 3 cycles each. done rises at edge 25, tabla=8'hE8, err_mask=8'h00, err_cnt=0, pass=1, first_err=0.
2. Same model, but Fpos inverted at abc=5 and at abc=2 -> err_mask=8'h24, err_cnt=2, first_err=2, pass=0, tabla=8'hE8.
3. Pulse start again at abc=4 while busy -> no effect: sweep completes at edge 25 after the original start. Then a fresh start clears done to 0 on the next cycle.
4. Assert rst for 1 cycle while abc_out=3 -> next cycle all outputs are 0 and state is IDLE. A restart then produces the scenario-1 results.
5. SETTLE_CYC=1, start held high -> done at edge 17. busy reasserts the cycle after DONE, and abc_out restarts at 0.
6. f_in tied 4'b0000 -> tabla=8'h00, pass=1. f_in tied 4'b0111 -> err_mask=8'hFF, err_cnt=8, first_err=0, pass=0.
